// File: rtl/lane_scroller.sv
// lane_scroller: one horizontal lane of scrolling obstacles.
//
// A WIDTH-bit shift register holds the lane image. New pixels come from a
// phase counter that emits `len` ones followed by `gap` zeros, repeating.
// After reset the lane is preloaded with one shift per clock for WIDTH clocks.
// It then scrolls by one pixel every (speed+1) base ticks. A base tick occurs
// every 2^TICK_BITS clocks.
//
// Ports
//   clock, reset        system clock, synchronous active-high reset
//   cfg_len, cfg_gap    obstacle length / gap (pixels), latched during reset
//   cfg_dir             0: shift toward MSB, 1: shift toward LSB (latched)
//   cfg_speed           base ticks per shift minus one (latched)
//   pause               freezes scrolling in RUN
//   blank               masks pixels/hit without touching internal state
//   frog_col            column tested by hit
//   pixels              lane image, bit 0 = column 0
//   ready               high while in RUN
//   hit                 pixels[frog_col], combinational
module lane_scroller #(
    parameter int WIDTH     = 16,
    parameter int TICK_BITS = 10,
    parameter int MAX_LEN   = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
    input  logic [2:0]                   cfg_gap,
    input  logic                         cfg_dir,
    input  logic [1:0]                   cfg_speed,
    input  logic                         pause,
    input  logic                         blank,
    input  logic [$clog2(WIDTH)-1:0]     frog_col,
    output logic [WIDTH-1:0]             pixels,
    output logic                         ready,
    output logic                         hit
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    // The phase must reach len+gap-1, and that value can be as large as MAX_LEN+6.
    localparam int PH_W  = $clog2(MAX_LEN + 8);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        RESET_HOLD = 2'd0,
        PRELOAD    = 2'd1,
        RUN        = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   lane_q, lane_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic [TICK_BITS-1:0] tick_q, tick_d;
    logic [1:0]         div_q, div_d;
    logic [CNT_W-1:0]   pre_q, pre_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [2:0]         gap_q, gap_d;
    logic               dir_q, dir_d;
    logic [1:0]         speed_q, speed_d;

    logic               do_shift;
    logic               ins_bit;
    logic [PH_W-1:0]    phase_last;
    logic [PH_W-1:0]    phase_adv;
    logic [WIDTH-1:0]   lane_shifted;

    // Pattern source and the shifted image, used by both PRELOAD and RUN.
    always_comb begin
        ins_bit      = phase_q < PH_W'(len_q);
        phase_last   = PH_W'(len_q) + PH_W'(gap_q) - PH_W'(1);
        phase_adv    = (phase_q == phase_last) ? '0 : phase_q + PH_W'(1);
        lane_shifted = dir_q ? {ins_bit, lane_q[WIDTH-1:1]}
                             : {lane_q[WIDTH-2:0], ins_bit};
    end

    always_comb begin
        state_d  = state_q;
        lane_d   = lane_q;
        phase_d  = phase_q;
        tick_d   = tick_q;
        div_d    = div_q;
        pre_d    = pre_q;
        len_d    = len_q;
        gap_d    = gap_q;
        dir_d    = dir_q;
        speed_d  = speed_q;
        do_shift = 1'b0;

        case (state_q)
            RESET_HOLD: state_d = PRELOAD;
            PRELOAD: begin
                // pause is deliberately ignored while preloading
                do_shift = 1'b1;
                pre_d    = pre_q + CNT_W'(1);
                if (pre_q == CNT_W'(WIDTH - 1)) begin
                    state_d = RUN;
                    pre_d   = '0;
                end
            end
            RUN: begin
                if (!pause) begin
                    tick_d = tick_q + TICK_BITS'(1);
                    if (&tick_q) begin
                        if (div_q == speed_q) begin
                            do_shift = 1'b1;
                            div_d    = '0;
                        end else begin
                            div_d = div_q + 2'd1;
                        end
                    end
                end
            end
            default: state_d = RESET_HOLD;
        endcase

        if (do_shift) begin
            lane_d  = lane_shifted;
            phase_d = phase_adv;
        end

        // Reset wins over everything. Configuration is re-latched and normalised
        // on every reset cycle, so a zero length or gap never reaches the phase logic.
        if (reset) begin
            state_d = RESET_HOLD;
            lane_d  = '0;
            phase_d = '0;
            tick_d  = '0;
            div_d   = '0;
            pre_d   = '0;
            if (cfg_len == '0)
                len_d = LEN_W'(1);
            else if (cfg_len > LEN_W'(MAX_LEN))
                len_d = LEN_W'(MAX_LEN);
            else
                len_d = cfg_len;
            gap_d   = (cfg_gap == 3'd0) ? 3'd1 : cfg_gap;
            dir_d   = cfg_dir;
            speed_d = cfg_speed;
        end
    end

    always_ff @(posedge clock) begin
        state_q <= state_d;
        lane_q  <= lane_d;
        phase_q <= phase_d;
        tick_q  <= tick_d;
        div_q   <= div_d;
        pre_q   <= pre_d;
        len_q   <= len_d;
        gap_q   <= gap_d;
        dir_q   <= dir_d;
        speed_q <= speed_d;
    end

    assign pixels = blank ? '0 : lane_q;
    assign ready  = (state_q == RUN);
    // Guard keeps non-power-of-two widths from indexing past the lane.
    assign hit    = (int'(frog_col) < WIDTH) && pixels[frog_col];

endmodule

// File: tb/tb_lane_scroller.sv
module tb_lane_scroller;

    localparam int W = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  cfg_len = 3'd3;
    logic [2:0]  cfg_gap = 3'd2;
    logic        cfg_dir = 1'b0;
    logic [1:0]  cfg_speed = 2'd0;
    logic        pause = 1'b0;
    logic        blank = 1'b0;
    logic [3:0]  frog_col = 4'd0;
    logic [15:0] pixels;
    logic        ready;
    logic        hit;

    int n_pass = 0;
    int n_tot  = 0;

    lane_scroller #(.WIDTH(16), .TICK_BITS(2), .MAX_LEN(4)) dut (
        .clock(clock), .reset(reset), .cfg_len(cfg_len), .cfg_gap(cfg_gap),
        .cfg_dir(cfg_dir), .cfg_speed(cfg_speed), .pause(pause), .blank(blank),
        .frog_col(frog_col), .pixels(pixels), .ready(ready), .hit(hit)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    endtask

    // Model: after k shifts, the pixel at each column is the pattern bit
    // inserted at a known index. Insertion index i carries ((i mod (len+gap)) < len).
    function automatic logic [15:0] img(input int k, input int len, input int gap, input int dir);
        logic [15:0] r;
        int idx;
        r = '0;
        for (int p = 0; p < W; p++) begin
            idx = dir ? (k - W + p) : (k - 1 - p);
            if (idx >= 0 && (idx % (len + gap)) < len) r[p] = 1'b1;
        end
        return r;
    endfunction

    bit m_valid = 0;
    int m_st = 0, m_k = 0, m_pre = 0, m_act = 0;
    int m_len = 1, m_gap = 1, m_dir = 0, m_spd = 0;

    always @(posedge clock) begin
        if (reset) begin
            m_valid <= 1;
            m_st    <= 0;
            m_k     <= 0;
            m_act   <= 0;
            m_pre   <= 0;
            m_len   <= (cfg_len == 0) ? 1 : ((cfg_len > 4) ? 4 : int'(cfg_len));
            m_gap   <= (cfg_gap == 0) ? 1 : int'(cfg_gap);
            m_dir   <= int'(cfg_dir);
            m_spd   <= int'(cfg_speed);
        end else begin
            case (m_st)
                0: begin m_st <= 1; m_pre <= 0; end
                1: begin
                    m_k   <= m_k + 1;
                    m_pre <= m_pre + 1;
                    if (m_pre == W - 1) m_st <= 2;
                end
                default: if (!pause) begin
                    m_act <= m_act + 1;
                    // one shift per (speed+1) ticks of 4 clocks each
                    if ((m_act + 1) % (4 * (m_spd + 1)) == 0) m_k <= m_k + 1;
                end
            endcase
        end
    end

    always @(negedge clock) begin
        logic [15:0] e;
        if (m_valid) begin
            e = blank ? 16'h0 : img(m_k, m_len, m_gap, m_dir);
            chk("model_pixels", 32'(pixels), 32'(e));
            chk("model_ready", 32'(ready), 32'(m_st == 2));
            chk("model_hit", 32'(hit), 32'(e[frog_col]));
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clock); #2; end
    endtask

    task automatic do_reset(input int l, input int g, input int d, input int s);
        cfg_len = 3'(l); cfg_gap = 3'(g); cfg_dir = 1'(d); cfg_speed = 2'(s);
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 60) begin step(1); n++; end
        if (!ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic wait_change(output int n);
        logic [15:0] old;
        old = pixels;
        n = 0;
        while (pixels == old && n < 100) begin step(1); n++; end
        if (pixels == old) chk("shift_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        // reset state
        step(1);
        chk("rst_pixels", 32'(pixels), 0);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_hit", 32'(hit), 0);

        // len=3 gap=2 dir=0 speed=0
        do_reset(3, 2, 0, 0);
        chk("after_rst_pixels", 32'(pixels), 0);
        wait_ready(n);
        chk("t1_latency", n, 17);
        chk("t1_img", 32'(pixels), 32'h0000E739);
        frog_col = 4'd3; #1 chk("hit_col3", 32'(hit), 1);
        frog_col = 4'd1; #1 chk("hit_col1", 32'(hit), 0);
        frog_col = 4'd0; #1 chk("hit_col0", 32'(hit), 1);
        step(3);
        chk("t1_hold", 32'(pixels), 32'h0000E739);
        step(1);
        chk("t1_shift", 32'(pixels), 32'h0000CE73);

        // len=1 gap=3 dir=1
        do_reset(1, 3, 1, 0);
        wait_ready(n);
        chk("t2_img", 32'(pixels), 32'h00001111);
        wait_change(n);
        chk("t2_shift1", 32'(pixels), 32'h00008888);
        wait_change(n);
        chk("t2_shift2", 32'(pixels), 32'h00004444);

        // speed=2 spacing, then a pause
        do_reset(3, 2, 0, 2);
        wait_ready(n);
        wait_change(n);
        chk("t3_first", n, 12);
        wait_change(n);
        chk("t3_gap", n, 12);
        step(2);
        pause = 1'b1; step(5); pause = 1'b0;
        wait_change(n);
        chk("t3_paused_gap", 7 + n, 17);

        // blank for 20 clocks
        frog_col = 4'd0;
        blank = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (i % 5 == 0) begin
                chk("blank_pixels", 32'(pixels), 0);
                chk("blank_hit", 32'(hit), 0);
            end
        end
        blank = 1'b0;
        step(3);

        // zero len/gap normalise to 1/1; mid-RUN reset
        do_reset(0, 0, 1, 0);
        wait_ready(n);
        chk("t5_img", 32'(pixels), 32'h00005555);
        step(6);
        reset = 1'b1; step(1);
        chk("midrun_pixels", 32'(pixels), 0);
        chk("midrun_ready", 32'(ready), 0);
        reset = 1'b0; step(1);
        chk("post_rst_pixels", 32'(pixels), 0);
        wait_ready(n);
        chk("t5_relatency", n, 16);
        chk("t5_img2", 32'(pixels), 32'h00005555);

        // length above MAX_LEN clamps to 4
        do_reset(7, 1, 1, 0);
        wait_ready(n);
        chk("clamp_img", 32'(pixels), 32'h0000BDEF);

        // reset mid-PRELOAD with new config
        do_reset(3, 2, 0, 0);
        step(5);
        do_reset(1, 3, 1, 0);
        wait_ready(n);
        chk("midpre_latency", n, 17);
        chk("midpre_img", 32'(pixels), 32'h00001111);
        step(10);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/lane_scroller.md
LANE_SCROLLER -- requirements
Module: lane_scroller

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning number of pixels in the lane.
REQ-002 SHALL have parameter TICK_BITS, default 10, meaning base tick every 2^TICK_BITS clocks.
REQ-003 SHALL have parameter MAX_LEN, default 4, meaning largest obstacle length in pixels.
REQ-004 SHALL have port clock  input  1  system clock.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port cfg_len  input  $clog2(MAX_LEN+1)  obstacle length, sampled during reset.
REQ-007 SHALL have port cfg_gap  input  3  empty pixels between obstacles, sampled during reset.
REQ-008 SHALL have port cfg_dir  input  1  0 = shift toward MSB, 1 = shift toward LSB, sampled during reset.
REQ-009 SHALL have port cfg_speed  input  2  base ticks per shift minus one, sampled during reset.
REQ-010 SHALL have port pause  input  1  freezes scrolling.
REQ-011 SHALL have port blank  input  1  masks the lane output.
REQ-012 SHALL have port frog_col  input  $clog2(WIDTH)  frog column under test.
REQ-013 SHALL have port pixels  output  WIDTH  lane image, bit 0 = column 0.
REQ-014 SHALL have port ready  output  1  high in RUN.
REQ-015 SHALL have port hit  output  1  combinational: pixels[frog_col].

Function
REQ-016 SHALL implement states RESET_HOLD, PRELOAD, RUN.
REQ-017 RESET_HOLD: entered on every reset cycle; SHALL latch cfg_* each reset cycle, and clear the shift register, phase, tick and divider counters.
REQ-018 Latched cfg_len of 0 SHALL be treated as 1; cfg_len above MAX_LEN SHALL be clamped to MAX_LEN; cfg_gap of 0 SHALL be treated as 1.
REQ-019 Pattern source: phase counter runs 0..len+gap-1 and wraps to 0; inserted bit = (phase < len); phase SHALL advance on every shift.
REQ-020 Shift, dir 0: reg <= {reg[WIDTH-2:0], bit}; dir 1: reg <= {bit, reg[WIDTH-1:1]}.
REQ-021 First cycle with reset low: RESET_HOLD -> PRELOAD.
REQ-022 PRELOAD SHALL shift once per clock for exactly WIDTH clocks, ignoring pause, then go to RUN.
REQ-023 RUN: tick counter SHALL free-run from 0 and raise a tick when all-ones; the divider SHALL count ticks, and on a tick with divider == speed, SHALL perform one shift and clear the divider.
REQ-024 pause high in RUN SHALL freeze the tick counter, divider, phase and register; resume continues with no lost or extra shift.
REQ-025 blank high SHALL force pixels and hit to 0 without altering internal state; deasserting blank SHALL restore the held image on the same cycle.
REQ-026 A reset asserted mid-PRELOAD or mid-RUN SHALL abort on that edge and re-latch configuration.
REQ-027 ready SHALL be 1 only in RUN.

Reset
REQ-028 During and on the cycle after reset: pixels = 0, ready = 0, hit = 0, state RESET_HOLD, all counters 0.

Verification (WIDTH=16, TICK_BITS=2)
REQ-029 len=3, gap=2, dir=0, speed=0: release reset -> ready rises 17 clocks later with pixels = 16'hE739; 4 clocks later pixels = 16'hCE73.
REQ-030 len=1, gap=3, dir=1: after preload, pixels = 16'h1111; after each shift, the image rotates right by one, e.g. 16'h8888 after the first shift.
REQ-031 speed=2 in RUN: shifts occur exactly 12 clocks apart; a 5-clock pause between shifts delays the next shift to 17 clocks.
REQ-032 blank=1 for 20 clocks in RUN: pixels = 0 and hit = 0 throughout; on release, pixels equal the image an unblanked run would show at that time.
REQ-033 frog_col=0 with pixels[0]=1 -> hit=1 in the same cycle; frog_col=3 with 16'hE739 -> hit=1; frog_col=1 with 16'hE739 -> hit=0.
REQ-034 cfg_len=0 and cfg_gap=0 -> preload gives 16'h5555; reset pulsed mid-RUN -> pixels=0 next cycle and a fresh preload follows.
